// File: rtl/mips_mc_controller.sv
// Multicycle control FSM for a MIPS register/ALU/PC datapath with handshaked shared memories
// and an access watchdog. Define MIPS_ILLEGAL_TRAP_EN to halt (sticky illegal) on unsupported instructions.
module mips_mc_controller #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_en,
   output logic             pc_en,
   output logic             regdst,
   output logic             alusrc,
   output logic             memtoreg,
   output logic             regwrite,
   output logic             pcsrc,
   output logic             jump,
   output logic [3:0]       alucontrol,
   output logic             mem_err,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);
   localparam int              WD_W    = $clog2(WAIT_MAX + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
   typedef enum logic [3:0] {C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL} cls_t;

   state_t          state;
   cls_t            cls;
   logic [5:0]      op_q, funct_q;
   logic [WD_W-1:0] wait_cnt;
   logic            trap_q;
   logic            is_rtype, alu_imm;
   logic            unused_instr_bits;

   assign unused_instr_bits = ^instr[25:6];

   function automatic logic [3:0] alu_code(input cls_t c);
      case (c)
         C_SUB, C_BEQ:              alu_code = 4'b0110;
         C_AND:                     alu_code = 4'b0000;
         C_OR:                      alu_code = 4'b0001;
         C_SLT:                     alu_code = 4'b0111;
         C_ADD, C_ADDI, C_LW, C_SW: alu_code = 4'b0010;
         default:                   alu_code = 4'b0000;
      endcase
   endfunction

   // Classification works off the controller's own copy of opcode/funct taken at fetch.
   always_comb begin
      cls = C_ILL;
      case (op_q)
         6'b000000:
            case (funct_q)
               6'b100000: cls = C_ADD;
               6'b100010: cls = C_SUB;
               6'b100100: cls = C_AND;
               6'b100101: cls = C_OR;
               6'b101010: cls = C_SLT;
               default:   cls = C_ILL;
            endcase
         6'b001000: cls = C_ADDI;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b000010: cls = C_J;
         default:   cls = C_ILL;
      endcase
   end

   assign is_rtype = (cls == C_ADD) || (cls == C_SUB) || (cls == C_AND) || (cls == C_OR) || (cls == C_SLT);
   assign alu_imm  = (cls == C_ADDI) || (cls == C_LW) || (cls == C_SW);

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_en      = 1'b0;
      pc_en      = 1'b0;
      regdst     = 1'b0;
      alusrc     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      pcsrc      = 1'b0;
      jump       = 1'b0;
      alucontrol = 4'b0000;
      illegal    = trap_q;
      case (state)
         S_FETCH: begin
            // The state register sits in FETCH during reset; the request must still stay low.
            imem_req = reset;
            ir_en    = reset & imem_ready;
         end
         S_DECODE: begin
            if (cls == C_ILL) begin
               illegal = 1'b1;
`ifndef MIPS_ILLEGAL_TRAP_EN
               pc_en   = 1'b1;
`endif
            end
         end
         S_EXEC: begin
            alucontrol = alu_code(cls);
            alusrc     = alu_imm;
            if (cls == C_BEQ) begin
               pcsrc = zero;
               pc_en = 1'b1;
            end
            if (cls == C_J) begin
               jump  = 1'b1;
               pc_en = 1'b1;
            end
         end
         S_MEM: begin
            alucontrol = alu_code(cls);
            alusrc     = alu_imm;
            dmem_req   = 1'b1;
            dmem_we    = (cls == C_SW);
            pc_en      = (cls == C_SW) & dmem_ready;
         end
         S_WB: begin
            alucontrol = alu_code(cls);
            alusrc     = alu_imm;
            regwrite   = 1'b1;
            regdst     = is_rtype;
            memtoreg   = (cls == C_LW);
            pc_en      = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_FETCH;
         op_q     <= '0;
         funct_q  <= '0;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
         trap_q   <= 1'b0;
         retired  <= '0;
      end else begin
         if (pc_en) retired <= retired + CNT_W'(1);
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  op_q    <= instr[31:26];
                  funct_q <= instr[5:0];
                  state   <= S_DECODE;
               end else if (wait_cnt == WD_LAST) begin
                  mem_err <= 1'b1;
                  state   <= S_HALT;
               end
               wait_cnt <= (imem_ready || wait_cnt == WD_LAST) ? '0 : wait_cnt + WD_W'(1);
            end
            S_DECODE: begin
               if (cls == C_ILL) begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                  trap_q <= 1'b1;
                  state  <= S_HALT;
`else
                  state  <= S_FETCH;
`endif
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (cls)
                  C_BEQ, C_J: state <= S_FETCH;
                  C_LW, C_SW: state <= S_MEM;
                  default:    state <= S_WB;
               endcase
            end
            S_MEM: begin
               // Ready arriving in the expiry cycle is still an acknowledge.
               if (dmem_ready) begin
                  state <= (cls == C_SW) ? S_FETCH : S_WB;
               end else if (wait_cnt == WD_LAST) begin
                  mem_err <= 1'b1;
                  state   <= S_HALT;
               end
               wait_cnt <= (dmem_ready || wait_cnt == WD_LAST) ? '0 : wait_cnt + WD_W'(1);
            end
            S_WB:    state <= S_FETCH;
            default: state <= S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: a per-instruction cycle-list model built from the
// instruction-class timing rules, compared against the DUT every cycle, plus literal checks.
module tb_mips_mc_controller;
   localparam int WAIT_MAX = 16;
   localparam int CNT_W    = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [31:0]      instr = '0;
   logic             zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic             imem_req, dmem_req, dmem_we, ir_en, pc_en, regdst, alusrc, memtoreg;
   logic             regwrite, pcsrc, jump, mem_err, illegal;
   logic [3:0]       alucontrol;
   logic [CNT_W-1:0] retired;

   mips_mc_controller #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_en(ir_en), .pc_en(pc_en),
      .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg), .regwrite(regwrite), .pcsrc(pcsrc),
      .jump(jump), .alucontrol(alucontrol), .mem_err(mem_err), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       imem_req, dmem_req, dmem_we, ir_en, pc_en, regdst, alusrc, memtoreg;
      logic       regwrite, pcsrc, jump, illegal;
      logic [3:0] aluc;
   } ctl_t;

   typedef struct {
      logic        ir, dr, z;
      logic [31:0] ins;
      ctl_t        exp;
      logic        merr;
   } cyc_t;

   typedef struct packed {
      bit         legal, rtype, imm, lw, sw, beq, jmp;
      logic [3:0] aluc;
   } info_t;

   localparam logic [31:0] I_ADD  = 32'h00221820, I_SUB = 32'h00221822, I_AND = 32'h00221824;
   localparam logic [31:0] I_OR   = 32'h00221825, I_SLT = 32'h0022182A, I_ADDI = 32'h20220005;
   localparam logic [31:0] I_LW   = 32'h8C220004, I_SW  = 32'h AC220004, I_BEQ = 32'h10220002;
   localparam logic [31:0] I_J    = 32'h08000010, I_BAD = 32'hFC000000, I_SLL = 32'h00000000;

   cyc_t q[$];
   int   errors = 0, checks = 0;
   int   model_ret = 0;
   bit   gen_merr = 0, gen_halted = 0, gen_trap = 0;
   int   n_cyc, n_ireq, n_dreq, n_regw, n_pcsrc, n_pcen, n_ill, pcen_at;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ctl_t sample();
      return {imem_req, dmem_req, dmem_we, ir_en, pc_en, regdst, alusrc, memtoreg,
              regwrite, pcsrc, jump, illegal, alucontrol};
   endfunction

   function automatic info_t decode(input logic [31:0] w);
      info_t      d;
      logic [5:0] op, fn;
      d  = '0;
      op = w[31:26];
      fn = w[5:0];
      d.legal = 1'b1;
      if (op == 6'h00) begin
         d.rtype = 1'b1;
         case (fn)
            6'h20:   d.aluc = 4'b0010;
            6'h22:   d.aluc = 4'b0110;
            6'h24:   d.aluc = 4'b0000;
            6'h25:   d.aluc = 4'b0001;
            6'h2A:   d.aluc = 4'b0111;
            default: d.legal = 1'b0;
         endcase
      end
      else if (op == 6'h08) begin d.imm = 1'b1; d.aluc = 4'b0010; end
      else if (op == 6'h23) begin d.lw  = 1'b1; d.aluc = 4'b0010; end
      else if (op == 6'h2B) begin d.sw  = 1'b1; d.aluc = 4'b0010; end
      else if (op == 6'h04) begin d.beq = 1'b1; d.aluc = 4'b0110; end
      else if (op == 6'h02) d.jmp = 1'b1;
      else d.legal = 1'b0;
      return d;
   endfunction

   task automatic push(input logic ir, input logic dr, input logic z, input logic [31:0] ins, input ctl_t e);
      cyc_t c;
      c.ir = ir; c.dr = dr; c.z = z; c.ins = ins; c.exp = e; c.merr = gen_merr;
      q.push_back(c);
   endtask

   // Halted controller: everything quiet, readies offered and ignored.
   task automatic push_halt(input int n, input logic [31:0] ins);
      ctl_t e;
      for (int k = 0; k < n; k++) begin
         e = '0;
         e.illegal = gen_trap;
         push(1'b1, 1'b1, 1'b0, ins, e);
      end
      gen_halted = 1'b1;
   endtask

   // A memory access: dly waiting cycles then the acknowledge, or a timeout after WAIT_MAX.
   task automatic mem_phase(input bit is_i, input int dly, input logic z, input logic [31:0] ins,
                            input ctl_t base, input bit done_pc, output bit ok);
      ctl_t e;
      int   n;
      n = (dly < WAIT_MAX) ? dly : WAIT_MAX;
      for (int k = 0; k < n; k++) push(1'b0, 1'b0, z, ins, base);
      if (dly >= WAIT_MAX) begin
         gen_merr = 1'b1;
         push_halt(3, ins);
         ok = 1'b0;
         return;
      end
      e = base;
      if (is_i) e.ir_en = 1'b1;
      e.pc_en = done_pc;
      push(is_i, !is_i, z, ins, e);
      ok = 1'b1;
   endtask

   task automatic gen_instr(input logic [31:0] ins, input int idly, input int ddly, input logic z);
      info_t d;
      ctl_t  e;
      bit    ok;
      if (gen_halted) return;
      d = decode(ins);
      e = '0;
      e.imem_req = 1'b1;
      mem_phase(1'b1, idly, z, ins, e, 1'b0, ok);
      if (!ok) return;
      e = '0;
      if (!d.legal) begin
         e.illegal = 1'b1;
`ifdef MIPS_ILLEGAL_TRAP_EN
         push(1'b0, 1'b0, z, ins, e);
         gen_trap = 1'b1;
         push_halt(3, ins);
`else
         e.pc_en = 1'b1;
         push(1'b0, 1'b0, z, ins, e);
`endif
         return;
      end
      push(1'b0, 1'b0, z, ins, e);
      e = '0;
      e.aluc   = d.aluc;
      e.alusrc = d.imm | d.lw | d.sw;
      if (d.beq || d.jmp) begin
         e.pcsrc = d.beq & z;
         e.jump  = d.jmp;
         e.pc_en = 1'b1;
         push(1'b0, 1'b0, z, ins, e);
         return;
      end
      push(1'b0, 1'b0, z, ins, e);
      if (d.lw || d.sw) begin
         e.dmem_req = 1'b1;
         e.dmem_we  = d.sw;
         mem_phase(1'b0, ddly, z, ins, e, d.sw, ok);
         if (!ok || d.sw) return;
         e.dmem_req = 1'b0;
         e.dmem_we  = 1'b0;
      end
      e.regwrite = 1'b1;
      e.regdst   = d.rtype;
      e.memtoreg = d.lw;
      e.pc_en    = 1'b1;
      push(1'b0, 1'b0, z, ins, e);
   endtask

   // The single compare process: drive at negedge, compare 1 ns later, one queue entry per cycle.
   task automatic run_queue();
      cyc_t c;
      ctl_t act;
      n_cyc = 0; n_ireq = 0; n_dreq = 0; n_regw = 0; n_pcsrc = 0; n_pcen = 0; n_ill = 0; pcen_at = 0;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(negedge clk);
         imem_ready = c.ir; dmem_ready = c.dr; zero = c.z; instr = c.ins;
         #1;
         act = sample();
         n_cyc++;
         check("ctl", 32'(act), 32'(c.exp));
         check("retired", 32'(retired), 32'(model_ret));
         check("mem_err", 32'(mem_err), 32'(c.merr));
         n_ireq  += int'(act.imem_req);
         n_dreq  += int'(act.dmem_req);
         n_regw  += int'(act.regwrite);
         n_pcsrc += int'(act.pcsrc);
         n_pcen  += int'(act.pc_en);
         n_ill   += int'(act.illegal);
         if (act.pc_en && pcen_at == 0) pcen_at = n_cyc;
         if (c.exp.pc_en) model_ret = (model_ret + 1) % (1 << CNT_W);
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
      reset = 1'b1;
      model_ret = 0; gen_merr = 1'b0; gen_halted = 1'b0; gen_trap = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1; instr = I_ADD;
      #1;
      check("reset_ctl", 32'(sample()), 32'd0);
      check("reset_retired", 32'(retired), 32'd0);
      check("reset_mem_err", 32'(mem_err), 32'd0);
      release_reset();
   endtask

   initial begin
      do_reset();

      gen_instr(I_ADD, 0, 0, 1'b0);
      run_queue();
      check("add_cycles", n_cyc, 4);
      check("add_regwrite_cycles", n_regw, 1);
      check("add_pc_en_at", pcen_at, 4);
      @(posedge clk); #1;
      check("add_retired", 32'(retired), 32'd1);

      gen_instr(I_SUB, 0, 0, 1'b0);
      gen_instr(I_AND, 0, 0, 1'b0);
      gen_instr(I_OR, 0, 0, 1'b0);
      gen_instr(I_SLT, 0, 0, 1'b0);
      gen_instr(I_ADDI, 0, 0, 1'b0);
      gen_instr(I_LW, 0, 0, 1'b0);
      gen_instr(I_SW, 0, 0, 1'b0);
      run_queue();

      gen_instr(I_LW, 0, 3, 1'b0);
      run_queue();
      check("lw_dmem_req_cycles", n_dreq, 4);
      check("lw_pc_en_at", pcen_at, 8);

      gen_instr(I_BEQ, 0, 0, 1'b1);
      gen_instr(I_BEQ, 0, 0, 1'b0);
      run_queue();
      check("beq_regwrite_cycles", n_regw, 0);
      check("beq_pcsrc_cycles", n_pcsrc, 1);
      check("beq_pc_en_cycles", n_pcen, 2);
      check("beq_pc_en_at", pcen_at, 3);

      gen_instr(I_J, 0, 0, 1'b0);
      gen_instr(I_SW, 0, 2, 1'b0);
      gen_instr(I_ADDI, 2, 0, 1'b0);
      gen_instr(I_ADD, WAIT_MAX - 1, 0, 1'b0);
      gen_instr(I_ADD, 0, 0, 1'b0);
      run_queue();
      @(posedge clk); #1;
      check("retired_wrapped", 32'(retired), 32'd0);
      check("late_ready_no_err", 32'(mem_err), 32'd0);

      gen_instr(I_ADD, WAIT_MAX, 0, 1'b0);
      run_queue();
      check("timeout_imem_req_cycles", n_ireq, 16);
      check("timeout_mem_err", 32'(mem_err), 32'd1);

      do_reset();
      gen_instr(I_ADD, 0, 0, 1'b0);
      gen_instr(I_SW, 0, 10, 1'b0);
      while (q.size() > 9) void'(q.pop_back());
      run_queue();
      check("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_dmem_we", 32'(dmem_we), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      release_reset();

      gen_instr(I_J, 0, 0, 1'b0);
      gen_instr(I_BAD, 0, 0, 1'b0);
      gen_instr(I_ADD, 0, 0, 1'b0);
      gen_instr(I_SLL, 0, 0, 1'b0);
      run_queue();
      @(posedge clk); #1;
`ifdef MIPS_ILLEGAL_TRAP_EN
      check("illegal_cycles", n_ill, 4);
      check("illegal_retired", 32'(retired), 32'd1);
      check("illegal_sticky", 32'(illegal), 32'd1);
`else
      check("illegal_cycles", n_ill, 2);
      check("illegal_retired", 32'(retired), 32'd4);
      check("illegal_pulse_clear", 32'(illegal), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
